// File: rtl/mmio_to_axi4_lite_bridge_if.sv
// mmio_if: MMIO req/ack port between a TIA-side host and a device.
//   read_req/read_index   host -> device, held until read_ack is sampled
//   read_ack/read_data    device -> host, ack is a one-cycle pulse
//   write_req/write_index/write_data  host -> device, held until write_ack
//   write_ack             device -> host, one-cycle pulse
interface mmio_if #(
   parameter int INDEX_WIDTH = 8,
   parameter int DATA_WIDTH  = 32
);
   logic                   read_req;
   logic                   read_ack;
   logic [INDEX_WIDTH-1:0] read_index;
   logic [DATA_WIDTH-1:0]  read_data;
   logic                   write_req;
   logic                   write_ack;
   logic [INDEX_WIDTH-1:0] write_index;
   logic [DATA_WIDTH-1:0]  write_data;

   modport device (
      input  read_req, read_index, write_req, write_index, write_data,
      output read_ack, read_data, write_ack
   );

   modport host (
      output read_req, read_index, write_req, write_index, write_data,
      input  read_ack, read_data, write_ack
   );
endinterface

// File: rtl/mmio_to_axi4_lite_bridge.sv
// mmio_to_axi4_lite_bridge: turns MMIO read/write requests into single
// AXI4-Lite master transactions, one outstanding at a time.
//   clock, reset        positive-edge clock, asynchronous active-high reset
//   device_interface    MMIO device side (req in, ack/read_data out)
//   M_AXI_AW*/W*/B*     AXI4-Lite write channels
//   M_AXI_AR*/R*        AXI4-Lite read channels
//   axi_error           sticky: some BRESP/RRESP was not OKAY (reset clears)
module mmio_to_axi4_lite_bridge #(
   parameter int AXI4_LITE_ADDRESS_WIDTH = 32,
   parameter int AXI4_LITE_DATA_WIDTH    = 32,
   parameter int TIA_MMIO_INDEX_WIDTH    = 8
) (
   input  logic                                clock,
   input  logic                                reset,
   mmio_if.device                              device_interface,
   output logic [AXI4_LITE_ADDRESS_WIDTH-1:0]  M_AXI_AWADDR,
   output logic [2:0]                          M_AXI_AWPROT,
   output logic                                M_AXI_AWVALID,
   input  logic                                M_AXI_AWREADY,
   output logic [AXI4_LITE_DATA_WIDTH-1:0]     M_AXI_WDATA,
   output logic [AXI4_LITE_DATA_WIDTH/8-1:0]   M_AXI_WSTRB,
   output logic                                M_AXI_WVALID,
   input  logic                                M_AXI_WREADY,
   input  logic [1:0]                          M_AXI_BRESP,
   input  logic                                M_AXI_BVALID,
   output logic                                M_AXI_BREADY,
   output logic [AXI4_LITE_ADDRESS_WIDTH-1:0]  M_AXI_ARADDR,
   output logic [2:0]                          M_AXI_ARPROT,
   output logic                                M_AXI_ARVALID,
   input  logic                                M_AXI_ARREADY,
   input  logic [AXI4_LITE_DATA_WIDTH-1:0]     M_AXI_RDATA,
   input  logic [1:0]                          M_AXI_RRESP,
   input  logic                                M_AXI_RVALID,
   output logic                                M_AXI_RREADY,
   output logic                                axi_error
);

   localparam int INDEX_SHIFT = AXI4_LITE_ADDRESS_WIDTH - TIA_MMIO_INDEX_WIDTH;

   typedef enum logic [2:0] {
      IDLE, WRITE_ISSUE, WRITE_RESPONSE, WRITE_ACK, READ_ISSUE, READ_DATA, READ_ACK
   } state_t;

   state_t                               state, state_n;
   logic [AXI4_LITE_ADDRESS_WIDTH-1:0]   awaddr_n, araddr_n;
   logic [AXI4_LITE_DATA_WIDTH-1:0]      wdata_n, read_data_n;
   logic                                 awvalid_n, wvalid_n, bready_n, arvalid_n, rready_n;
   logic                                 read_ack_n, write_ack_n, axi_error_n;
   logic                                 last_was_read, last_was_read_n;

   assign M_AXI_AWPROT = 3'b000;
   assign M_AXI_ARPROT = 3'b000;
   assign M_AXI_WSTRB  = '1;

   // Every output is the registered copy of a next-value computed here, so
   // each output changes in the same cycle as the state it belongs to.
   always_comb begin
      state_n         = state;
      awaddr_n        = M_AXI_AWADDR;
      araddr_n        = M_AXI_ARADDR;
      wdata_n         = M_AXI_WDATA;
      read_data_n     = device_interface.read_data;
      awvalid_n       = M_AXI_AWVALID;
      wvalid_n        = M_AXI_WVALID;
      bready_n        = M_AXI_BREADY;
      arvalid_n       = M_AXI_ARVALID;
      rready_n        = M_AXI_RREADY;
      read_ack_n      = 1'b0;
      write_ack_n     = 1'b0;
      axi_error_n     = axi_error;
      last_was_read_n = last_was_read;
      case (state)
         IDLE: begin
            // On contention the type not served last wins.
            if (device_interface.write_req && (!device_interface.read_req || last_was_read)) begin
               state_n         = WRITE_ISSUE;
               awaddr_n        = AXI4_LITE_ADDRESS_WIDTH'(device_interface.write_index) << INDEX_SHIFT;
               wdata_n         = device_interface.write_data;
               awvalid_n       = 1'b1;
               wvalid_n        = 1'b1;
               last_was_read_n = 1'b0;
            end else if (device_interface.read_req) begin
               state_n         = READ_ISSUE;
               araddr_n        = AXI4_LITE_ADDRESS_WIDTH'(device_interface.read_index) << INDEX_SHIFT;
               arvalid_n       = 1'b1;
               last_was_read_n = 1'b1;
            end
         end
         WRITE_ISSUE: begin
            // A channel counts as accepted once its valid has been dropped,
            // so AW and W may complete in any order.
            awvalid_n = M_AXI_AWVALID && !M_AXI_AWREADY;
            wvalid_n  = M_AXI_WVALID && !M_AXI_WREADY;
            if ((!M_AXI_AWVALID || M_AXI_AWREADY) && (!M_AXI_WVALID || M_AXI_WREADY)) begin
               state_n  = WRITE_RESPONSE;
               bready_n = 1'b1;
            end
         end
         WRITE_RESPONSE: begin
            if (M_AXI_BVALID) begin
               state_n     = WRITE_ACK;
               bready_n    = 1'b0;
               write_ack_n = 1'b1;
               if (M_AXI_BRESP != 2'b00) axi_error_n = 1'b1;
            end
         end
         READ_ISSUE: begin
            if (M_AXI_ARREADY) begin
               state_n   = READ_DATA;
               arvalid_n = 1'b0;
               rready_n  = 1'b1;
            end
         end
         READ_DATA: begin
            if (M_AXI_RVALID) begin
               state_n     = READ_ACK;
               rready_n    = 1'b0;
               read_ack_n  = 1'b1;
               read_data_n = (M_AXI_RRESP == 2'b00) ? M_AXI_RDATA : '0;
               if (M_AXI_RRESP != 2'b00) axi_error_n = 1'b1;
            end
         end
         WRITE_ACK, READ_ACK: state_n = IDLE;
         default:             state_n = IDLE;
      endcase
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state                      <= IDLE;
         M_AXI_AWADDR               <= '0;
         M_AXI_ARADDR               <= '0;
         M_AXI_WDATA                <= '0;
         M_AXI_AWVALID              <= 1'b0;
         M_AXI_WVALID               <= 1'b0;
         M_AXI_BREADY               <= 1'b0;
         M_AXI_ARVALID              <= 1'b0;
         M_AXI_RREADY               <= 1'b0;
         device_interface.read_data <= '0;
         device_interface.read_ack  <= 1'b0;
         device_interface.write_ack <= 1'b0;
         axi_error                  <= 1'b0;
         last_was_read              <= 1'b1;
      end else begin
         state                      <= state_n;
         M_AXI_AWADDR               <= awaddr_n;
         M_AXI_ARADDR               <= araddr_n;
         M_AXI_WDATA                <= wdata_n;
         M_AXI_AWVALID              <= awvalid_n;
         M_AXI_WVALID               <= wvalid_n;
         M_AXI_BREADY               <= bready_n;
         M_AXI_ARVALID              <= arvalid_n;
         M_AXI_RREADY               <= rready_n;
         device_interface.read_data <= read_data_n;
         device_interface.read_ack  <= read_ack_n;
         device_interface.write_ack <= write_ack_n;
         axi_error                  <= axi_error_n;
         last_was_read              <= last_was_read_n;
      end
   end

endmodule
